// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One producer's pending register-file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// NREQ-wide one-hot arbiter: round-robin when WB_ARB_ROUND_ROBIN_EN is defined, else fixed priority (index 0 wins).
// Latency: combinational grant; the round-robin pointer updates at the edge after a grant.
// Backpressure: none; a grant is always issued when any request is valid.
//
// Ports:
//   clk, rst_n : clock and async active-low reset (only used by the round-robin pointer)
//   req        : request vector, one bit per requester
//   grant      : one-hot grant, all zero when req is zero
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant
);

`ifdef WB_ARB_ROUND_ROBIN_EN

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Pointer holds the index that currently has top priority.
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found;
    int               idx;

    // Search starts at the pointer and wraps; the winner's successor
    // becomes the next top-priority index.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                ptr_d      = PTR_W'((idx + 1) % NREQ);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`else

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Fixed priority is stateless; clock and reset are intentionally unused.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n};

`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates NREQ writeback producers onto the single register-file write port and tracks busy destinations.
// Latency: 1 cycle from handshake to rf_we/rf_waddr/rf_wdata; busy clears at the handshake edge.
// Backpressure: write port accepts every cycle; losers simply wait with valid held (starvation-free only with WB_ARB_ROUND_ROBIN_EN).
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : per-requester handshake; req_ready is combinational and one-hot
//   req_waddr/req_wdata   : per-requester destination/data, packed {i=NREQ-1..0}
//   rf_we/rf_waddr/rf_wdata : registered register-file write
//   sb_set/sb_addr        : issue allocates a destination (marks busy)
//   sb_flush              : clears the whole scoreboard (beats sb_set)
//   chk_addr1/2, hazard1/2: busy lookup for issue operands, 0 for x0
//   busy                  : full scoreboard, bit 0 always 0
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*5-1:0]      req_waddr,
    input  logic [NREQ*XLEN-1:0]   req_wdata,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    input  logic                   sb_set,
    input  logic [4:0]             sb_addr,
    input  logic                   sb_flush,
    input  logic [4:0]             chk_addr1,
    input  logic [4:0]             chk_addr2,
    output logic                   hazard1,
    output logic                   hazard2,
    output logic [31:0]            busy
);

    wb_req_t              reqs [NREQ];
    wb_req_t              sel;
    logic [NREQ-1:0]      grant;
    logic                 any_grant;
    logic                 commit_we;
    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqs[i].waddr = req_waddr[i*REG_ADDR_W +: REG_ADDR_W];
            reqs[i].wdata = DATA_W'(req_wdata[i*XLEN +: XLEN]);
        end
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .grant (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;

    // Grant is one-hot, so the first match is the only match.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel = reqs[i];
            end
        end
    end

    // x0 writes complete the handshake but never raise the write enable.
    assign commit_we = any_grant && (sel.waddr != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (any_grant) begin
            rf_we    <= commit_we;
            rf_waddr <= sel.waddr;
            rf_wdata <= XLEN'(sel.wdata);
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Ordering encodes the priorities: commit clear, then allocation set
    // (a new producer outranks the retiring one), then flush over everything.
    always_comb begin
        busy_d = busy_q;
        if (commit_we) begin
            busy_d[sel.waddr] = 1'b0;
        end
        if (sb_set && (sb_addr != REG_ZERO)) begin
            busy_d[sb_addr] = 1'b1;
        end
        if (sb_flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Bit 0 is never set, so x0 lookups read back 0 without a special case.
    assign busy    = busy_q;
    assign hazard1 = busy_q[chk_addr1];
    assign hazard2 = busy_q[chk_addr2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (fixed-priority or round-robin build).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled later in the same cycle.
// Backpressure: n/a.
module tb_rf_wb_arbiter;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [14:0]  req_waddr;
    logic [95:0]  req_wdata;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         sb_set;
    logic [4:0]   sb_addr;
    logic         sb_flush;
    logic [4:0]   chk_addr1;
    logic [4:0]   chk_addr2;
    logic         hazard1;
    logic         hazard2;
    logic [31:0]  busy;

    logic [4:0]   wa [3];
    logic [31:0]  wd [3];

    int n_cmp;
    int n_fail;

    assign req_waddr = {wa[2], wa[1], wa[0]};
    assign req_wdata = {wd[2], wd[1], wd[0]};

    rf_wb_arbiter #(
        .NREQ (3),
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_waddr (req_waddr),
        .req_wdata (req_wdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .sb_flush  (sb_flush),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        sb_set    = 1'b0;
        sb_addr   = '0;
        sb_flush  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wa[i] = '0;
            wd[i] = '0;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        chk_addr1 = 5'd0;
        chk_addr2 = 5'd0;
        idle_inputs();
        #12;
        n_cmp++; if (rf_we !== 1'b0)     begin n_fail++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
        n_cmp++; if (rf_waddr !== 5'd0)  begin n_fail++; $display("FAIL reset_rf_waddr got %0d exp 0", rf_waddr); end
        n_cmp++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata got %h exp 0", rf_wdata); end
        n_cmp++; if (busy !== 32'd0)     begin n_fail++; $display("FAIL reset_busy got %h exp 0", busy); end
        n_cmp++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b exp 000", req_ready); end
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        logic [2:0] exp_rdy [3];
        logic [4:0] exp_wa  [3];
`ifdef WB_ARB_ROUND_ROBIN_EN
        exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100;
        exp_wa[0]  = 5'd1;   exp_wa[1]  = 5'd2;   exp_wa[2]  = 5'd3;
`else
        exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b001; exp_rdy[2] = 3'b001;
        exp_wa[0]  = 5'd1;   exp_wa[1]  = 5'd1;   exp_wa[2]  = 5'd1;
`endif
        // Fresh reset so the round-robin pointer starts at 0.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        wa[0] = 5'd1; wd[0] = 32'h0000_0011;
        wa[1] = 5'd2; wd[1] = 32'h0000_0022;
        wa[2] = 5'd3; wd[2] = 32'h0000_0033;
        req_valid = 3'b111;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (req_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL contend_ready[%0d] got %b exp %b", k, req_ready, exp_rdy[k]); end
            tick();
            n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== exp_wa[k]) begin n_fail++; $display("FAIL contend_commit[%0d] got we=%b addr=%0d exp we=1 addr=%0d", k, rf_we, rf_waddr, exp_wa[k]); end
        end
        // Requester 0 idle: both schemes pick requester 1 (pointer is back at 0 under round-robin).
        req_valid = 3'b110;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL contend_110_ready got %b exp 010", req_ready); end
        tick();
        n_cmp++; if (rf_waddr !== 5'd2 || rf_wdata !== 32'h22) begin n_fail++; $display("FAIL contend_110_commit got addr=%0d data=%h exp addr=2 data=22", rf_waddr, rf_wdata); end
        idle_inputs();
        tick();
        n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd2) begin n_fail++; $display("FAIL idle_hold got we=%b addr=%0d exp we=0 addr=2", rf_we, rf_waddr); end
    endtask

    task automatic test_single_write();
        sb_set = 1'b1; sb_addr = 5'd5;
        tick();
        sb_set = 1'b0;
        chk_addr1 = 5'd5;
        chk_addr2 = 5'd0;
        #1;
        n_cmp++; if (busy[5] !== 1'b1 || hazard1 !== 1'b1 || hazard2 !== 1'b0) begin n_fail++; $display("FAIL single_busy_set got busy5=%b h1=%b h2=%b exp 1 1 0", busy[5], hazard1, hazard2); end
        tick();
        req_valid = 3'b001; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready got %b exp 001", req_ready); end
        n_cmp++; if (hazard1 !== 1'b1) begin n_fail++; $display("FAIL single_hazard_same_cycle got %b exp 1", hazard1); end
        tick();
        req_valid = 3'b000;
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_commit got we=%b addr=%0d data=%h exp 1 5 deadbeef", rf_we, rf_waddr, rf_wdata); end
        n_cmp++; if (busy[5] !== 1'b0 || hazard1 !== 1'b0) begin n_fail++; $display("FAIL single_busy_clear got busy5=%b h1=%b exp 0 0", busy[5], hazard1); end
        tick();
        n_cmp++; if (rf_we !== 1'b0 || rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_hold got we=%b data=%h exp 0 deadbeef", rf_we, rf_wdata); end
    endtask

    task automatic test_x0_write();
        sb_set = 1'b1; sb_addr = 5'd4;
        tick();
        sb_set = 1'b0;
        req_valid = 3'b010; wa[1] = 5'd0; wd[1] = 32'h0000_1234;
        #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL x0_ready got %b exp 010", req_ready); end
        tick();
        req_valid = 3'b000;
        n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL x0_commit got we=%b addr=%0d data=%h exp 0 0 1234", rf_we, rf_waddr, rf_wdata); end
        n_cmp++; if (busy !== 32'h0000_0010) begin n_fail++; $display("FAIL x0_busy got %h exp 00000010", busy); end
        chk_addr2 = 5'd4;
        #1;
        n_cmp++; if (hazard2 !== 1'b1) begin n_fail++; $display("FAIL x0_hazard2 got %b exp 1", hazard2); end
    endtask

    task automatic test_set_clear_collision();
        tick();
        req_valid = 3'b001; wa[0] = 5'd7; wd[0] = 32'h0000_0777;
        sb_set = 1'b1; sb_addr = 5'd7;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL collide_ready got %b exp 001", req_ready); end
        tick();
        idle_inputs();
        n_cmp++; if (busy !== 32'h0000_0090) begin n_fail++; $display("FAIL collide_busy got %h exp 00000090", busy); end
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin n_fail++; $display("FAIL collide_commit got we=%b addr=%0d exp 1 7", rf_we, rf_waddr); end
    endtask

    task automatic test_flush();
        sb_flush = 1'b1;
        tick();
        sb_flush = 1'b0;
        n_cmp++; if (busy !== 32'd0) begin n_fail++; $display("FAIL flush_plain got %h exp 0", busy); end
        sb_set = 1'b1; sb_addr = 5'd3;
        tick();
        sb_addr = 5'd9;
        tick();
        sb_set = 1'b0;
        n_cmp++; if (busy !== 32'h0000_0208) begin n_fail++; $display("FAIL flush_preset got %h exp 00000208", busy); end
        sb_flush = 1'b1;
        sb_set = 1'b1; sb_addr = 5'd12;
        req_valid = 3'b001; wa[0] = 5'd3; wd[0] = 32'hCAFE_0003;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL flush_ready got %b exp 001", req_ready); end
        tick();
        idle_inputs();
        n_cmp++; if (busy !== 32'd0) begin n_fail++; $display("FAIL flush_busy got %h exp 0", busy); end
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hCAFE_0003) begin n_fail++; $display("FAIL flush_commit got we=%b addr=%0d data=%h exp 1 3 cafe0003", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_async_reset();
        sb_set = 1'b1; sb_addr = 5'd6;
        req_valid = 3'b100; wa[2] = 5'd10; wd[2] = 32'h0000_A5A5;
        #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL areset_ready got %b exp 100", req_ready); end
        tick();
        sb_set = 1'b0;
        n_cmp++; if (rf_we !== 1'b1 || busy !== 32'h0000_0040) begin n_fail++; $display("FAIL areset_pre got we=%b busy=%h exp 1 00000040", rf_we, busy); end
        // Another grant is pending when reset drops between edges.
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rf_we !== 1'b0 || busy !== 32'd0 || rf_waddr !== 5'd0) begin n_fail++; $display("FAIL areset_immediate got we=%b busy=%h addr=%0d exp 0 0 0", rf_we, busy, rf_waddr); end
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL areset_release got we=%b exp 0", rf_we); end
        // Pointer is back at 0: full contention grants requester 0 in both schemes.
        req_valid = 3'b111;
        wa[0] = 5'd1; wa[1] = 5'd2;
        #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL areset_ptr got %b exp 001", req_ready); end
        tick();
        idle_inputs();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1) begin n_fail++; $display("FAIL areset_after got we=%b addr=%0d exp 1 1", rf_we, rf_waddr); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_contention();
        test_single_write();
        test_x0_write();
        test_set_clear_collision();
        test_flush();
        test_async_reset();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback producers (ALU, load unit, mul/div) using valid/ready handshakes.
- Registers the winning write onto rf_we/rf_waddr/rf_wdata one cycle later.
- Keeps a 32-entry busy scoreboard of pending destination registers so issue logic can stall on RAW hazards.
- Sits between the execute/memory units and the register file.

Parameters:
- NREQ, 3, number of writeback requesters; index 0 is highest fixed priority.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  requester i granted this cycle; combinational.
- req_waddr  in  NREQ*5  destination of requester i, packed {i=NREQ-1..0}.
- req_wdata  in  NREQ*XLEN  data of requester i, packed likewise.
- rf_we  out  1  write enable to register file; registered.
- rf_waddr  out  5  write address; registered.
- rf_wdata  out  XLEN  write data; registered.
- sb_set  in  1  issue stage allocates destination sb_addr.
- sb_addr  in  5  destination being allocated.
- sb_flush  in  1  pipeline flush: clear all busy bits.
- chk_addr1  in  5  issue read operand 1 address.
- chk_addr2  in  5  issue read operand 2 address.
- hazard1  out  1  busy[chk_addr1]; combinational from the busy register.
- hazard2  out  1  busy[chk_addr2]; combinational from the busy register.
- busy  out  32  full scoreboard vector; bit 0 is constant 0.

Behaviour:
- Reset values (async, rst_n low): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, arbitration pointer=0. Reset mid-operation discards any registered write, so rf_we is 0 in the first cycle after release.
- Arbitration, combinational:
  - At most one req_ready bit is high per cycle, and only for a requester with req_valid=1.
  - With no valid requests, req_ready=0.
  - The write port never back-pressures, so the output stage accepts every cycle.
- Commit, 1-cycle latency: on a cycle with grant to i, at the next edge rf_we<=(req_waddr[i]!=0), rf_waddr<=req_waddr[i], rf_wdata<=req_wdata[i].
- No grant: rf_we<=0; rf_waddr and rf_wdata hold.
- x0 writes are accepted (handshake completes) and dropped: rf_we stays 0.
- Handshake: the transfer happens when req_valid[i]&&req_ready[i]. A requester holds valid, waddr and wdata stable until ready; it must not drop valid while waiting.
- Scoreboard, per bit r, evaluated at the edge:
  - set when sb_set && sb_addr==r && r!=0;
  - clear when the commit register is loaded with rf_we for r, i.e. the handshake cycle, not the rf_we cycle.
  - Same-cycle set and clear of the same r: set wins (new producer).
  - sb_flush clears every bit. If sb_set and sb_flush coincide, flush wins.
  - A grant in the flush cycle still commits to the register file.
- Hazards:
  - hazard1/2 = busy[chk_addr], and are 0 for address 0.
  - They do not reflect same-cycle commits; issue sees the clear one cycle after the handshake.
- Starvation: none under round-robin. Under fixed priority the requester protocol must tolerate indefinite wait.

Optional Feature:
- Macro: WB_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - A pointer register holds the index with current top priority.
  - After a grant to i, the pointer becomes (i+1) mod NREQ.
  - The search starts at the pointer and wraps around.
  - The pointer is unchanged in cycles with no grant.
- Undefined: fixed priority, lowest index wins. No pointer register exists.

Decomposition:
- Shared package rf_pkg holds:
  - constants REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0;
  - typedef wb_req_t {waddr, wdata}.
- One sub-module, rr_arbiter (NREQ-wide, with the round-robin/fixed behaviour selected by the macro), produces a one-hot grant from req_valid.
- Scoreboard and commit register live in rf_wb_arbiter.

Test Plan:
- Single write: req_valid=3'b001, waddr=5, wdata=0xDEADBEEF, busy[5] set two cycles earlier. Required: req_ready=001 the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; busy[5]=0 and hazard1=0 for chk_addr1=5.
- Contention: all three requesters valid with waddr 1/2/3 held.
  - Round-robin: grants 0,1,2 in consecutive cycles; rf_waddr sequence 1,2,3.
  - Fixed priority: grant 0 each cycle while valid[0] stays high.
- x0 write: requester 1 writes waddr=0, wdata=0x1234. Required: ready=010, next cycle rf_we=0, busy unchanged.
- Set/clear collision: sb_set with sb_addr=7 in the same cycle as a grant writing x7. Required: busy[7]=1 afterwards; rf_we=1 for x7 next cycle.
- Flush: busy={x3,x9} with a grant to x3 in the flush cycle. Required: busy=0 next cycle and rf_we=1, rf_waddr=3 still committed.
- Async reset mid-stream: assert rst_n=0 between edges while a grant is pending. Required: rf_we, busy and pointer are 0 immediately, and rf_we=0 in the first cycle after release.
